// File: rtl/id_issue_scoreboard_pkg.sv
// Shared types and encodings for the ID-stage issue scoreboard.
// Slots carry the destination register and the stage at which the result exists.
package id_issue_scoreboard_pkg;
    localparam int SB_REGW = 5;

    localparam logic [2:0] WT_EXE  = 3'b100;
    localparam logic [2:0] WT_MEM  = 3'b010;
    localparam logic [2:0] WT_WB   = 3'b001;
    localparam logic [2:0] WT_NONE = 3'b000;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic               v;
        logic [SB_REGW-1:0] wnum;
        logic [2:0]         wtype;
    } slot_t;
endpackage

// File: rtl/id_issue_scoreboard_resolve.sv
// Per-operand hazard resolver: finds the youngest in-flight writer of src
// and decides between forwarding from its stage or stalling.
module idsb_resolve
    import id_issue_scoreboard_pkg::*;
#(
    parameter int REGW = SB_REGW
) (
    input  logic [REGW-1:0] src,
    input  logic            rd_en,
    input  logic            early,
    input  slot_t           exe_slot,
    input  slot_t           mem_slot,
    input  slot_t           wb_slot,
    output logic            stall,
    output logic [1:0]      fwd
);
    logic hit_exe;
    logic hit_mem;
    logic hit_wb;

    assign hit_exe = exe_slot.v && (exe_slot.wnum == src);
    assign hit_mem = mem_slot.v && (mem_slot.wnum == src);
    assign hit_wb  = wb_slot.v  && (wb_slot.wnum  == src);

    // A pushed entry always has a nonzero wtype, so a WB hit is always usable.
    always_comb begin
        stall = 1'b0;
        fwd   = FWD_RF;
        if (rd_en && (src != '0)) begin
            if (hit_exe) begin
                if (exe_slot.wtype[2] && !early) fwd = FWD_EXE;
                else                             stall = 1'b1;
            end else if (hit_mem) begin
                if (mem_slot.wtype[2] || mem_slot.wtype[1]) fwd = FWD_MEM;
                else                                        stall = 1'b1;
            end else if (hit_wb) begin
                fwd = FWD_WB;
            end
        end
    end
endmodule

// File: rtl/id_issue_scoreboard.sv
// Decode-stage issue controller: shadows EXE/MEM/WB destinations, resolves
// RAW hazards per operand and counts stall cycles.
module id_issue_scoreboard
    import id_issue_scoreboard_pkg::*;
#(
    parameter int REGW  = SB_REGW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [2:0]       id_read_type,
    input  logic [2:0]       id_write_type,
    input  logic [REGW-1:0]  id_wnum,
    input  logic             exe_allowin,
    input  logic             flush,
    output logic             id_ready,
    output logic             id_issue,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic [CNT_W-1:0] stall_cnt
);
    slot_t exe_slot;
    slot_t mem_slot;
    slot_t wb_slot;
    slot_t push_slot;
    logic  rs_stall;
    logic  rt_stall;

    idsb_resolve #(.REGW(REGW)) u_rs (
        .src      (id_rs),
        .rd_en    (id_read_type[0]),
        .early    (id_read_type[2]),
        .exe_slot (exe_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .stall    (rs_stall),
        .fwd      (fwd_rs)
    );

    idsb_resolve #(.REGW(REGW)) u_rt (
        .src      (id_rt),
        .rd_en    (id_read_type[1]),
        .early    (id_read_type[2]),
        .exe_slot (exe_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .stall    (rt_stall),
        .fwd      (fwd_rt)
    );

    assign id_ready = !(rs_stall || rt_stall);
    assign id_issue = id_valid && id_ready && exe_allowin && !flush;

    // Writes to r0 or with no result are pushed as bubbles so they never match.
    always_comb begin
        push_slot.v     = id_issue && (id_wnum != '0) && (id_write_type != WT_NONE);
        push_slot.wnum  = id_wnum;
        push_slot.wtype = id_write_type;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_slot  <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            stall_cnt <= '0;
        end else begin
            if (exe_allowin) begin
                wb_slot  <= mem_slot;
                mem_slot <= exe_slot;
                exe_slot <= push_slot;
            end
            if (id_valid && !id_ready && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Directed and random checks of id_issue_scoreboard against an
// instruction-age reference model of the in-flight results.
module tb_id_issue_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [2:0]  id_read_type;
    logic [2:0]  id_write_type;
    logic [4:0]  id_wnum;
    logic        exe_allowin;
    logic        flush;
    logic        id_ready;
    logic        id_issue;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic [15:0] stall_cnt;

    int passCount = 0;
    int failCount = 0;
    int totalCount = 0;

    // Reference: index 0 is the youngest in-flight instruction (in EXE).
    logic       mv [3];
    logic [4:0] mw [3];
    logic [2:0] mt [3];
    int         mcnt;
    logic       expReady;
    logic       expIssue;
    logic [1:0] expFwdRs;
    logic [1:0] expFwdRt;

    id_issue_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_read_type  (id_read_type),
        .id_write_type (id_write_type),
        .id_wnum       (id_wnum),
        .exe_allowin   (exe_allowin),
        .flush         (flush),
        .id_ready      (id_ready),
        .id_issue      (id_issue),
        .fwd_rs        (fwd_rs),
        .fwd_rt        (fwd_rt),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic int readyStage(input logic [2:0] t);
        case (t)
            3'b100:  return 0;
            3'b010:  return 1;
            default: return 2;
        endcase
    endfunction

    function automatic void resolveRef(input logic [4:0] src, input logic en, input logic early,
                                       output logic st, output logic [1:0] fw);
        st = 1'b0;
        fw = 2'd0;
        if (en && src != 5'd0) begin
            for (int s = 0; s < 3; s++) begin
                if (mv[s] && mw[s] == src) begin
                    if (s >= readyStage(mt[s]) && !(early && s == 0)) fw = 2'(s + 1);
                    else st = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then compare every output at the falling edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [2:0] rtype,
                                 input logic [2:0] wtype, input logic [4:0] wnum,
                                 input logic allow, input logic fl);
        logic sRs, sRt;
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_read_type = rtype;
        id_write_type = wtype; id_wnum = wnum; exe_allowin = allow; flush = fl;
        resolveRef(rs, rtype[0], rtype[2], sRs, expFwdRs);
        resolveRef(rt, rtype[1], rtype[2], sRt, expFwdRt);
        expReady = !(sRs || sRt);
        expIssue = v && expReady && allow && !fl;
        @(negedge clk);
        checkOutput("id_ready", 32'(id_ready), 32'(expReady));
        checkOutput("id_issue", 32'(id_issue), 32'(expIssue));
        checkOutput("fwd_rs", 32'(fwd_rs), 32'(expFwdRs));
        checkOutput("fwd_rt", 32'(fwd_rt), 32'(expFwdRt));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(mcnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < 3; s++) begin mv[s] = 1'b0; mw[s] = '0; mt[s] = '0; end
            mcnt = 0;
        end else begin
            if (id_valid && !expReady && !flush && mcnt != 16'hFFFF) mcnt++;
            if (exe_allowin) begin
                for (int s = 2; s > 0; s--) begin mv[s] = mv[s-1]; mw[s] = mw[s-1]; mt[s] = mt[s-1]; end
                mv[0] = expIssue && id_wnum != 5'd0 && id_write_type != 3'b000;
                mw[0] = id_wnum;
                mt[0] = id_write_type;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
            tick();
        end
    endtask

    initial begin
        logic [2:0] wtypes [4];
        int cntBefore;
        wtypes[0] = 3'b000; wtypes[1] = 3'b100; wtypes[2] = 3'b010; wtypes[3] = 3'b001;
        for (int s = 0; s < 3; s++) begin mv[s] = 1'b0; mw[s] = '0; mt[s] = '0; end
        mcnt = 0;
        #1;

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0); tick();
        applyStimulus(1, 1, 3, 4, 3'b011, 3'b000, 0, 1, 0); tick();
        applyStimulus(0, 1, 1, 2, 3'b011, 3'b000, 0, 1, 0);
        checkOutput("reset_ready", 32'(id_ready), 32'd1);
        checkOutput("reset_cnt", 32'(stall_cnt), 32'd0);
        tick();

        $display("[TB] alu dependency");
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b100, 5, 1, 0); tick();
        applyStimulus(0, 1, 5, 0, 3'b001, 3'b000, 0, 0, 0);
        checkOutput("alu_fwd_exe", 32'(fwd_rs), 32'd1);
        tick();
        applyStimulus(0, 0, 5, 0, 3'b001, 3'b000, 0, 1, 0); tick();
        applyStimulus(0, 1, 5, 0, 3'b001, 3'b000, 0, 1, 0);
        checkOutput("alu_fwd_mem", 32'(fwd_rs), 32'd2);
        tick();

        $display("[TB] load use");
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b010, 8, 1, 0); tick();
        cntBefore = int'(stall_cnt);
        applyStimulus(0, 1, 0, 8, 3'b010, 3'b000, 0, 1, 0);
        checkOutput("lu_stall", 32'(id_ready), 32'd0);
        tick();
        applyStimulus(0, 1, 0, 8, 3'b010, 3'b000, 0, 1, 0);
        checkOutput("lu_cnt", 32'(stall_cnt), 32'(cntBefore + 1));
        checkOutput("lu_fwd_mem", 32'(fwd_rt), 32'd2);
        tick();

        $display("[TB] branch early read");
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b100, 3, 1, 0); tick();
        applyStimulus(0, 1, 3, 0, 3'b101, 3'b000, 0, 1, 0);
        checkOutput("br_stall", 32'(id_ready), 32'd0);
        tick();
        applyStimulus(0, 1, 3, 0, 3'b101, 3'b000, 0, 1, 0);
        checkOutput("br_fwd_mem", 32'(fwd_rs), 32'd2);
        tick();

        $display("[TB] youngest wins");
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b100, 4, 1, 0); tick();
        idle(1);
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b001, 4, 1, 0); tick();
        applyStimulus(0, 1, 4, 0, 3'b001, 3'b000, 0, 0, 0);
        checkOutput("yw_stall", 32'(id_ready), 32'd0);
        tick();
        applyStimulus(1, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0); tick();
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b100, 4, 1, 0); tick();
        idle(2);
        applyStimulus(0, 1, 4, 0, 3'b001, 3'b000, 0, 0, 0);
        checkOutput("yw_fwd_wb", 32'(fwd_rs), 32'd3);
        tick();

        $display("[TB] backpressure, flush, zero register");
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b100, 7, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 3'b000, 3'b100, 9, 0, 0);
            checkOutput("bp_no_issue", 32'(id_issue), 32'd0);
            tick();
        end
        applyStimulus(0, 1, 7, 0, 3'b001, 3'b000, 0, 0, 0);
        checkOutput("bp_frozen", 32'(fwd_rs), 32'd1);
        tick();
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b010, 10, 1, 0); tick();
        cntBefore = int'(stall_cnt);
        applyStimulus(0, 1, 10, 0, 3'b001, 3'b100, 9, 1, 1);
        checkOutput("fl_no_issue", 32'(id_issue), 32'd0);
        tick();
        applyStimulus(0, 1, 9, 0, 3'b001, 3'b000, 0, 1, 0);
        checkOutput("fl_cnt", 32'(stall_cnt), 32'(cntBefore));
        checkOutput("fl_bubble", 32'(fwd_rs), 32'd0);
        tick();
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b010, 0, 1, 0); tick();
        applyStimulus(0, 1, 0, 0, 3'b011, 3'b000, 0, 1, 0);
        checkOutput("zero_ready", 32'(id_ready), 32'd1);
        tick();

        $display("[TB] random");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 3'($urandom), wtypes[$urandom_range(0, 3)],
                          5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0));
            tick();
        end

        $display("[TB] saturation");
        applyStimulus(1, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0); tick();
        applyStimulus(0, 1, 0, 0, 3'b000, 3'b001, 6, 1, 0); tick();
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(0, 1, 6, 0, 3'b001, 3'b000, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 1, 6, 0, 3'b001, 3'b000, 0, 0, 0);
        checkOutput("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
        tick();
        applyStimulus(1, 1, 6, 0, 3'b001, 3'b000, 0, 0, 0); tick();
        applyStimulus(0, 1, 6, 6, 3'b011, 3'b000, 0, 1, 0);
        checkOutput("post_rst_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("post_rst_ready", 32'(id_ready), 32'd1);
        checkOutput("post_rst_fwd", 32'({fwd_rs, fwd_rt}), 32'd0);
        tick();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
